conv_pe_sequencer: RTL and testbench
====================================

Name: conv_pe_sequencer

Overview:
- Control sequencer for the CONV sub-top. It generates the IFM and weight BRAM read addresses, the per-PE accumulate enables (PE_en) and the per-PE end-of-dot-product strobes (PE_finish) for one convolution tile.
- It sits between the layer-level controller (start/config/done) and the BRAM-plus-PE_cluster datapath.
- It iterates over output pixels. For each pixel it walks cfg_words 32-bit words of IFM and weight data, and aligns enables to the BRAM read latency.

Parameters:
- NUM_PE, 16, number of PEs driven by PE_en and PE_finish.
- IFM_AW, 7, IFM BRAM address width.
- W_AW, 20, weight BRAM address width.
- CNT_W, 16, width of the word and pixel counters.
- RD_LAT, 1, BRAM read latency in cycles (range 1..3).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to launch a tile; sampled only in IDLE.
- cfg_words  in  CNT_W  number of 32-bit words per dot product.
- cfg_pixels  in  CNT_W  number of output pixels in the tile.
- cfg_ifm_base  in  IFM_AW  IFM address of word 0 of pixel 0.
- cfg_ifm_stride  in  IFM_AW  IFM address step between consecutive pixels.
- cfg_w_base  in  W_AW  weight address of word 0; identical for every pixel.
- cfg_pe_mask  in  NUM_PE  PEs that participate in the tile.
- stall  in  1  downstream back-pressure; while high, no word is issued.
- ifm_addr  out  IFM_AW  IFM BRAM read address.
- w_addr  out  W_AW  weight read address, broadcast to all weight BRAMs.
- PE_en  out  NUM_PE  accumulate enable, aligned with BRAM data.
- PE_finish  out  NUM_PE  marks the final word of the current pixel.
- pixel_idx  out  CNT_W  index of the pixel currently being issued.
- busy  out  1  high while in RUN or DRAIN.
- done  out  1  one-cycle pulse at tile completion.

Behaviour:
- Reset (asynchronous): state goes to IDLE. ifm_addr, w_addr, PE_en, PE_finish, pixel_idx, busy and done all go to 0. The internal pipeline is cleared. A reset asserted mid-tile aborts the tile immediately; no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, all cfg_* inputs are latched.
  - If cfg_words==0 or cfg_pixels==0, go to DONE with no PE_en activity.
  - Otherwise go to RUN. ifm_addr is loaded with cfg_ifm_base, w_addr with cfg_w_base, and the counters k and pixel_idx are cleared.
  - cfg_* inputs are ignored outside IDLE. start is ignored while busy or in DONE.
- RUN, issue rule:
  - A word is issued on any RUN cycle with stall==0. The issued word uses the ifm_addr/w_addr values driven in that cycle.
  - After an issue, k increments and both addresses increment by 1.
  - When k==cfg_words-1, the issue is flagged "last": k returns to 0, w_addr reloads cfg_w_base, the pixel base advances by cfg_ifm_stride, ifm_addr takes the new pixel base, and pixel_idx increments.
  - The issue that is last for pixel cfg_pixels-1 moves the state to DRAIN.
  - While stall==1, addresses and counters hold.
- Alignment pipeline: a RD_LAT-deep shift register carries (valid, last) and shifts on every cycle, including stall cycles, which insert valid=0.
  - PE_en = cfg_pe_mask when the delayed valid is 1, else 0.
  - PE_finish = cfg_pe_mask when the delayed valid and delayed last are both 1, else 0.
  - PE_en and PE_finish are registered; they never repeat a word.
- DRAIN: waits until the pipeline is empty (RD_LAT cycles after the final issue), then goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Address arithmetic is unsigned and wraps modulo 2^IFM_AW and 2^W_AW. No saturation, no error flag.
- Timing with start sampled at edge 0, no stall, RD_LAT=1, W words and P pixels:
  - First issue in cycle 1; first PE_en in cycle 2.
  - Final PE_en/PE_finish in cycle W*P+1.
  - done in cycle W*P+2.
- Each stall cycle adds exactly one cycle.
- A stall asserted during DRAIN or DONE has no effect.

Test Plan:
- Basic tile: W=3, P=2, ifm_base=10, stride=4, w_base=100, mask=0xFFFF.
  - ifm_addr sequence 10,11,12,14,15,16; w_addr sequence 100,101,102,100,101,102.
  - PE_en=0xFFFF in cycles 2..7; PE_finish=0xFFFF in cycles 4 and 7; done in cycle 8.
- Stall: same config, stall high in cycles 2..3.
  - Address 11 held for 3 cycles; PE_en low in cycles 3..4.
  - Exactly 6 enable cycles in total; done in cycle 10.
- Degenerate sizes:
  - W=0 or P=0: done in cycle 1, PE_en never set.
  - W=1, P=3, mask=0x00F0: PE_en and PE_finish both 0x00F0 in cycles 2..4.
- Wrap-around: ifm_base=126, W=4, P=1 → ifm_addr sequence 126,127,0,1.
- Reset mid-RUN, then busy-start: assert reset in cycle 3 of the basic tile.
  - All outputs 0 immediately, no done; a fresh start then runs the full tile.
  - Separately, start while busy is ignored and the config is unchanged.
- RD_LAT=2: the basic tile has its first PE_en in cycle 3 and done in cycle 9.

Source files
------------

// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer
//   Control sequencer for one convolution tile. Walks output pixels, and for
//   each pixel walks cfg_words 32-bit words, producing IFM and weight BRAM read
//   addresses. PE accumulate enables and end-of-dot-product strobes are
//   delayed by RD_LAT cycles so they line up with the BRAM read data.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle tile launch, only honoured in IDLE
//   cfg_*             tile configuration, latched on an accepted start
//   stall             back-pressure; no word is issued while high
//   ifm_addr, w_addr  BRAM read addresses for the word issued this cycle
//   PE_en, PE_finish  per-PE accumulate enable / final-word strobe
//   pixel_idx         index of the pixel currently being issued
//   busy, done        RUN/DRAIN indicator, one-cycle completion pulse
module conv_pe_sequencer #(
  parameter int NUM_PE = 16,
  parameter int IFM_AW = 7,
  parameter int W_AW   = 20,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_words,
  input  logic [CNT_W-1:0]  cfg_pixels,
  input  logic [IFM_AW-1:0] cfg_ifm_base,
  input  logic [IFM_AW-1:0] cfg_ifm_stride,
  input  logic [W_AW-1:0]   cfg_w_base,
  input  logic [NUM_PE-1:0] cfg_pe_mask,
  input  logic              stall,
  output logic [IFM_AW-1:0] ifm_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic [NUM_PE-1:0] PE_en,
  output logic [NUM_PE-1:0] PE_finish,
  output logic [CNT_W-1:0]  pixel_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [CNT_W-1:0]    pixels_q, pixels_d;
  logic [IFM_AW-1:0]   stride_q, stride_d;
  logic [W_AW-1:0]     w_base_q, w_base_d;
  logic [NUM_PE-1:0]   mask_q, mask_d;
  logic [IFM_AW-1:0]   pix_base_q, pix_base_d;
  logic [IFM_AW-1:0]   ifm_addr_q, ifm_addr_d;
  logic [W_AW-1:0]     w_addr_q, w_addr_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    pixel_idx_q, pixel_idx_d;
  logic [NUM_PE-1:0]   pe_en_q, pe_en_d;
  logic [NUM_PE-1:0]   pe_fin_q, pe_fin_d;

  // Issue decode kept outside the FSM process so the alignment taps depend
  // only on flops and inputs.
  logic issue, issue_last;
  assign issue      = (state_q == RUN) && !stall;
  assign issue_last = issue && (k_q == words_q - 1'b1);

  // vld_tap[i]/last_tap[i]: word issued i cycles ago. Tap 0 is the live issue;
  // the PE_en/PE_finish registers form the final stage, so RD_LAT-1 extra
  // flop stages are needed.
  logic [RD_LAT-1:0] vld_tap, last_tap;
  assign vld_tap[0]  = issue;
  assign last_tap[0] = issue_last;

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
      logic vld_q, last_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end else begin
          vld_q  <= vld_tap[gi-1];
          last_q <= last_tap[gi-1];
        end
      end
      assign vld_tap[gi]  = vld_q;
      assign last_tap[gi] = last_q;
    end
  endgenerate

  // True while an issued word is still in flight ahead of the PE_en register.
  logic pipe_busy;
  generate
    if (RD_LAT > 1) begin : g_pbusy
      assign pipe_busy = |vld_tap[RD_LAT-1:1];
    end else begin : g_pidle
      assign pipe_busy = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    pixels_d    = pixels_q;
    stride_d    = stride_q;
    w_base_d    = w_base_q;
    mask_d      = mask_q;
    pix_base_d  = pix_base_q;
    ifm_addr_d  = ifm_addr_q;
    w_addr_d    = w_addr_q;
    k_d         = k_q;
    pixel_idx_d = pixel_idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          words_d     = cfg_words;
          pixels_d    = cfg_pixels;
          stride_d    = cfg_ifm_stride;
          w_base_d    = cfg_w_base;
          mask_d      = cfg_pe_mask;
          pix_base_d  = cfg_ifm_base;
          ifm_addr_d  = cfg_ifm_base;
          w_addr_d    = cfg_w_base;
          k_d         = '0;
          pixel_idx_d = '0;
          state_d     = (cfg_words == '0 || cfg_pixels == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue_last) begin
          // Next pixel: restart the word walk from the new pixel base.
          k_d         = '0;
          w_addr_d    = w_base_q;
          pix_base_d  = pix_base_q + stride_q;
          ifm_addr_d  = pix_base_q + stride_q;
          pixel_idx_d = pixel_idx_q + 1'b1;
          if (pixel_idx_q == pixels_q - 1'b1) state_d = DRAIN;
        end else if (issue) begin
          k_d        = k_q + 1'b1;
          ifm_addr_d = ifm_addr_q + 1'b1;
          w_addr_d   = w_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pe_en_d  = vld_tap[RD_LAT-1] ? mask_q : '0;
  assign pe_fin_d = (vld_tap[RD_LAT-1] && last_tap[RD_LAT-1]) ? mask_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      words_q     <= '0;
      pixels_q    <= '0;
      stride_q    <= '0;
      w_base_q    <= '0;
      mask_q      <= '0;
      pix_base_q  <= '0;
      ifm_addr_q  <= '0;
      w_addr_q    <= '0;
      k_q         <= '0;
      pixel_idx_q <= '0;
      pe_en_q     <= '0;
      pe_fin_q    <= '0;
    end else begin
      state_q     <= state_d;
      words_q     <= words_d;
      pixels_q    <= pixels_d;
      stride_q    <= stride_d;
      w_base_q    <= w_base_d;
      mask_q      <= mask_d;
      pix_base_q  <= pix_base_d;
      ifm_addr_q  <= ifm_addr_d;
      w_addr_q    <= w_addr_d;
      k_q         <= k_d;
      pixel_idx_q <= pixel_idx_d;
      pe_en_q     <= pe_en_d;
      pe_fin_q    <= pe_fin_d;
    end
  end

  assign ifm_addr  = ifm_addr_q;
  assign w_addr    = w_addr_q;
  assign PE_en     = pe_en_q;
  assign PE_finish = pe_fin_q;
  assign pixel_idx = pixel_idx_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed testbench for conv_pe_sequencer. Two instances share stimulus:
// dut (RD_LAT=1) is checked in full, dut2 (RD_LAT=2) on enable/done timing.
module tb_conv_pe_sequencer;
  localparam int NUM_PE = 16;
  localparam int IFM_AW = 7;
  localparam int W_AW   = 20;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset, start, stall;
  logic [CNT_W-1:0]  cfg_words, cfg_pixels;
  logic [IFM_AW-1:0] cfg_ifm_base, cfg_ifm_stride;
  logic [W_AW-1:0]   cfg_w_base;
  logic [NUM_PE-1:0] cfg_pe_mask;

  logic [IFM_AW-1:0] ifm_addr, ifm_addr2;
  logic [W_AW-1:0]   w_addr, w_addr2;
  logic [NUM_PE-1:0] pe_en, pe_fin, pe_en2, pe_fin2;
  logic [CNT_W-1:0]  pixel_idx, pixel_idx2;
  logic              busy, done, busy2, done2;

  conv_pe_sequencer #(.NUM_PE(NUM_PE), .IFM_AW(IFM_AW), .W_AW(W_AW),
                      .CNT_W(CNT_W), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_words(cfg_words),
    .cfg_pixels(cfg_pixels), .cfg_ifm_base(cfg_ifm_base),
    .cfg_ifm_stride(cfg_ifm_stride), .cfg_w_base(cfg_w_base),
    .cfg_pe_mask(cfg_pe_mask), .stall(stall), .ifm_addr(ifm_addr),
    .w_addr(w_addr), .PE_en(pe_en), .PE_finish(pe_fin),
    .pixel_idx(pixel_idx), .busy(busy), .done(done));

  conv_pe_sequencer #(.NUM_PE(NUM_PE), .IFM_AW(IFM_AW), .W_AW(W_AW),
                      .CNT_W(CNT_W), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .cfg_words(cfg_words),
    .cfg_pixels(cfg_pixels), .cfg_ifm_base(cfg_ifm_base),
    .cfg_ifm_stride(cfg_ifm_stride), .cfg_w_base(cfg_w_base),
    .cfg_pe_mask(cfg_pe_mask), .stall(stall), .ifm_addr(ifm_addr2),
    .w_addr(w_addr2), .PE_en(pe_en2), .PE_finish(pe_fin2),
    .pixel_idx(pixel_idx2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives start for the edge that ends cycle 0; returns in cycle 1.
  task automatic launch(input logic [15:0] w, input logic [15:0] p,
                        input logic [6:0] ib, input logic [6:0] is,
                        input logic [19:0] wb, input logic [15:0] m);
    cfg_words = w; cfg_pixels = p; cfg_ifm_base = ib; cfg_ifm_stride = is;
    cfg_w_base = wb; cfg_pe_mask = m;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  // W=3, P=2, base 10, stride 4, w_base 100, all PEs.
  task automatic basic_tile(input string tag);
    int ifm_e[6] = '{10, 11, 12, 14, 15, 16};
    int w_e[6]   = '{100, 101, 102, 100, 101, 102};
    launch(16'd3, 16'd2, 7'd10, 7'd4, 20'd100, 16'hFFFF);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 6) begin
        chk($sformatf("%s ifm c%0d", tag, c), 32'(ifm_addr), ifm_e[c-1]);
        chk($sformatf("%s w c%0d", tag, c), 32'(w_addr), w_e[c-1]);
      end
      chk($sformatf("%s en c%0d", tag, c), 32'(pe_en), (c >= 2 && c <= 7) ? 32'hFFFF : 32'h0);
      chk($sformatf("%s fin c%0d", tag, c), 32'(pe_fin), (c == 4 || c == 7) ? 32'hFFFF : 32'h0);
      chk($sformatf("%s done c%0d", tag, c), 32'(done), (c == 8) ? 32'd1 : 32'd0);
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), (c <= 7) ? 32'd1 : 32'd0);
      chk($sformatf("%s en2 c%0d", tag, c), 32'(pe_en2), (c >= 3 && c <= 8) ? 32'hFFFF : 32'h0);
      chk($sformatf("%s done2 c%0d", tag, c), 32'(done2), (c == 9) ? 32'd1 : 32'd0);
      $display("%s cycle %0d: ifm=%0d w=%0d en=%h fin=%h done=%b en2=%h done2=%b",
               tag, c, ifm_addr, w_addr, pe_en, pe_fin, done, pe_en2, done2);
      if (c < 9) tick();
    end
    chk({tag, " pixel_idx end"}, 32'(pixel_idx), 32'd2);
    settle();
  endtask

  initial begin
    int en_count;
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    cfg_words = '0; cfg_pixels = '0; cfg_ifm_base = '0; cfg_ifm_stride = '0;
    cfg_w_base = '0; cfg_pe_mask = '0;
    #1 reset = 1'b1;
    #2;
    chk("reset ifm", 32'(ifm_addr), 32'd0);
    chk("reset w", 32'(w_addr), 32'd0);
    chk("reset en", 32'(pe_en), 32'd0);
    chk("reset fin", 32'(pe_fin), 32'd0);
    chk("reset pix", 32'(pixel_idx), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    $display("reset: outputs cleared");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    basic_tile("basic");

    // Stall in cycles 2..3.
    launch(16'd3, 16'd2, 7'd10, 7'd4, 20'd100, 16'hFFFF);
    en_count = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 4) chk($sformatf("stall ifm c%0d", c), 32'(ifm_addr), (c == 1) ? 32'd10 : 32'd11);
      chk($sformatf("stall en c%0d", c), 32'(pe_en),
          (c == 2 || (c >= 5 && c <= 9)) ? 32'hFFFF : 32'h0);
      chk($sformatf("stall fin c%0d", c), 32'(pe_fin), (c == 6 || c == 9) ? 32'hFFFF : 32'h0);
      chk($sformatf("stall done c%0d", c), 32'(done), (c == 10) ? 32'd1 : 32'd0);
      if (pe_en != '0) en_count++;
      $display("stall cycle %0d: ifm=%0d en=%h done=%b", c, ifm_addr, pe_en, done);
      stall = (c == 2 || c == 3);
      if (c < 10) tick();
    end
    stall = 1'b0;
    chk("stall en count", en_count, 32'd6);
    settle();

    // W=0 then P=0.
    launch(16'd0, 16'd2, 7'd10, 7'd4, 20'd100, 16'hFFFF);
    chk("w0 done", 32'(done), 32'd1);
    chk("w0 en", 32'(pe_en), 32'd0);
    chk("w0 busy", 32'(busy), 32'd0);
    tick();
    chk("w0 done off", 32'(done), 32'd0);
    chk("w0 en off", 32'(pe_en), 32'd0);
    $display("W=0: done in cycle 1");
    settle();
    launch(16'd3, 16'd0, 7'd10, 7'd4, 20'd100, 16'hFFFF);
    chk("p0 done", 32'(done), 32'd1);
    chk("p0 en", 32'(pe_en), 32'd0);
    tick();
    chk("p0 en off", 32'(pe_en), 32'd0);
    $display("P=0: done in cycle 1");
    settle();

    // W=1, P=3, mask 0x00F0.
    launch(16'd1, 16'd3, 7'd10, 7'd4, 20'd100, 16'h00F0);
    for (int c = 1; c <= 5; c++) begin
      if (c <= 3) begin
        chk($sformatf("w1 ifm c%0d", c), 32'(ifm_addr), 32'(10 + 4 * (c - 1)));
        chk($sformatf("w1 w c%0d", c), 32'(w_addr), 32'd100);
      end
      chk($sformatf("w1 en c%0d", c), 32'(pe_en), (c >= 2 && c <= 4) ? 32'h00F0 : 32'h0);
      chk($sformatf("w1 fin c%0d", c), 32'(pe_fin), (c >= 2 && c <= 4) ? 32'h00F0 : 32'h0);
      chk($sformatf("w1 done c%0d", c), 32'(done), (c == 5) ? 32'd1 : 32'd0);
      $display("w1p3 cycle %0d: ifm=%0d en=%h fin=%h done=%b", c, ifm_addr, pe_en, pe_fin, done);
      if (c < 5) tick();
    end
    settle();

    // IFM address wrap.
    launch(16'd4, 16'd1, 7'd126, 7'd1, 20'd5, 16'hFFFF);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) chk($sformatf("wrap ifm c%0d", c), 32'(ifm_addr), 32'((125 + c) % 128));
      chk($sformatf("wrap done c%0d", c), 32'(done), (c == 6) ? 32'd1 : 32'd0);
      $display("wrap cycle %0d: ifm=%0d done=%b", c, ifm_addr, done);
      if (c < 6) tick();
    end
    settle();

    // Reset in cycle 3 of the basic tile.
    launch(16'd3, 16'd2, 7'd10, 7'd4, 20'd100, 16'hFFFF);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid reset ifm", 32'(ifm_addr), 32'd0);
    chk("mid reset w", 32'(w_addr), 32'd0);
    chk("mid reset en", 32'(pe_en), 32'd0);
    chk("mid reset fin", 32'(pe_fin), 32'd0);
    chk("mid reset pix", 32'(pixel_idx), 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset en2", 32'(pe_en2), 32'd0);
    $display("mid-run reset: outputs cleared");
    #2 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("post reset done t%0d", c), 32'(done | done2), 32'd0);
      chk($sformatf("post reset busy t%0d", c), 32'(busy), 32'd0);
    end
    basic_tile("restart");

    // Start while busy with a different config must be ignored.
    launch(16'd3, 16'd2, 7'd10, 7'd4, 20'd100, 16'hFFFF);
    cfg_words = 16'd1; cfg_pixels = 16'd1; cfg_ifm_base = 7'd50;
    cfg_ifm_stride = 7'd9; cfg_w_base = 20'd7; cfg_pe_mask = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      if (c <= 6) begin
        chk($sformatf("busystart ifm c%0d", c), 32'(ifm_addr),
            (c <= 3) ? 32'(9 + c) : 32'(10 + c));
        chk($sformatf("busystart w c%0d", c), 32'(w_addr),
            (c <= 3) ? 32'(99 + c) : 32'(96 + c));
      end
      chk($sformatf("busystart en c%0d", c), 32'(pe_en), (c <= 7) ? 32'hFFFF : 32'h0);
      chk($sformatf("busystart done c%0d", c), 32'(done), (c == 8) ? 32'd1 : 32'd0);
      $display("busystart cycle %0d: ifm=%0d w=%0d en=%h done=%b", c, ifm_addr, w_addr, pe_en, done);
      if (c < 8) tick();
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
